hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline. It drives the write-enable ("advance") and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- It detects load-use hazards, memory wait states, taken branches and HLT. It sequences the pipeline drain on HLT and reports when the pipeline is halted.
- It sits beside the pipeline registers and is the producer of the per-stage write-enable each of them consumes.

Parameters:
- OP_LW, 4'b1000, load opcode
- OP_HLT, 4'b1111, halt opcode
- DRAIN_CYC, 3, cycles for HLT to travel ID->WB

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- id_op  in  4  opcode in ID
- id_rs  in  4  ID source register 1
- id_rt  in  4  ID source register 2
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_op  in  4  opcode in EX
- ex_rd  in  4  EX destination register
- branch_taken  in  1  branch resolved taken in ID
- imem_busy  in  1  instruction memory not ready this cycle
- mem_busy  in  1  data memory not ready for MEM-stage access
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- id_ex_we  out  1  ID/EX write enable
- ex_mem_we  out  1  EX/MEM write enable
- mem_wb_we  out  1  MEM/WB write enable
- if_id_flush  out  1  load NOP into IF/ID at next edge
- id_ex_flush  out  1  load NOP bubble into ID/EX at next edge
- halted  out  1  pipeline halted
- stall_cnt  out  16  stall-cycle counter

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values (while `rst`=1):
  - FSM state = RUN, drain counter = 0.
  - All *_we = 0, both flushes = 0, halted = 0, stall_cnt = 0.
- FSM states: RUN, DRAIN, HALTED.
- Outputs are combinational from state and inputs; halted and stall_cnt are registered.
- Load-use hazard (lu): ex_op==OP_LW && ex_rd!=0 && ((id_uses_rs && ex_rd==id_rs) || (id_uses_rt && ex_rd==id_rt)). Register $0 never creates a hazard.
- Priority in RUN, highest first:
  1. mem_busy=1: all *_we=0, flushes=0 (full freeze).
  2. lu=1: pc_we=0, if_id_we=0, id_ex_flush=1; id_ex_we, ex_mem_we, mem_wb_we = 1; branch_taken and HLT ignored this cycle. Lasts exactly one cycle because the bubble clears ex_op.
  3. id_op==OP_HLT: pc_we=0, if_id_flush=1, other *_we=1; drain counter loads DRAIN_CYC; next state DRAIN.
  4. branch_taken=1: if_id_flush=1, all *_we=1 (squashes the fetched instruction).
  5. imem_busy=1: pc_we=0, if_id_flush=1, other *_we=1.
  6. Otherwise: all *_we=1, flushes=0.
- If branch_taken and imem_busy are both high: if_id_flush=1 and pc_we=0.
- DRAIN:
  - pc_we=0, if_id_flush=1; id_ex_we, ex_mem_we, mem_wb_we = 1 unless mem_busy, which freezes everything and holds the counter.
  - Counter decrements on each non-frozen edge.
  - Edge where the counter goes 1->0: next state HALTED.
- HALTED: all *_we=0, flushes=0, halted=1. Remains until `rst`.
- stall_cnt:
  - Increments on each edge where state==RUN, not in reset, and pc_we==0 due to mem_busy, lu or imem_busy.
  - Saturates at 16'hFFFF; DRAIN and HALTED cycles are not counted.
- Reset asserted mid-DRAIN or mid-stall: state returns immediately to RUN and all outputs take their reset values.

Optional Feature:
- Macro: HZRD_PERF_EN.
- Defined: stall_cnt counter is implemented as above.
- Undefined: no counter flops; stall_cnt is tied to 16'h0000.

Test Plan:
- Reset mid-stall: `rst` pulsed while mem_busy=1 -> outputs immediately all 0; after release with idle inputs, all *_we=1 and stall_cnt=0.
- Load-use: ex_op=4'h8, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle of pc_we=0, if_id_we=0, id_ex_flush=1, mem_wb_we=1. Next cycle with ex_op=4'h0 -> all *_we=1. stall_cnt=1 (HZRD_PERF_EN).
- No hazard on $0: ex_op=4'h8, ex_rd=0, id_rs=0 -> all *_we=1, no flush.
- Memory wait: mem_busy=1 for 3 cycles -> all *_we=0 for exactly those 3 cycles; stall_cnt increases by 3. Without HZRD_PERF_EN, stall_cnt stays 0.
- Branch versus load-use: branch_taken=1 alone -> if_id_flush=1 for one cycle. branch_taken=1 together with lu=1 -> if_id_flush=0, id_ex_flush=1.
- Halt drain: id_op=4'hF -> DRAIN; halted=1 after 3 edges. With mem_busy=1 for 2 cycles during DRAIN, halted=1 after 5 edges. Thereafter all *_we=0 until `rst`.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Produces the write-enable and flush of the PC and each pipeline register,
// resolves load-use, memory wait, branch and HLT, sequences the HLT drain
// and reports the halted state.
// Optional feature macro: HZRD_PERF_EN (stall-cycle counter on stall_cnt;
// when undefined stall_cnt is tied to zero and no counter flops exist).
module hazard_ctrl #(
  parameter logic [3:0] OP_LW     = 4'b1000,
  parameter logic [3:0] OP_HLT    = 4'b1111,
  parameter int         DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_op,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [3:0]  ex_op,
  input  logic [3:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        imem_busy,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam int CW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_DRAIN  = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   drain_cnt_r;
  logic [CW-1:0]   drain_cnt_nxt_s;
  logic            lu_s;

  // Load-use: a load in EX writes a register the ID instruction reads ($0 excluded).
  assign lu_s = (ex_op == OP_LW) && (ex_rd != 4'd0) &&
                ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

  // Halted flag comes straight from the state flop, so it is registered.
  assign halted = (state_r == S_HALTED);

  // State and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_RUN;
      drain_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // Next-state and per-stage enable/flush decode; reset forces everything low.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    pc_we           = 1'b0;
    if_id_we        = 1'b0;
    id_ex_we        = 1'b0;
    ex_mem_we       = 1'b0;
    mem_wb_we       = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    if (rst) begin
      state_nxt_s     = S_RUN;
      drain_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        S_RUN: begin
          if (mem_busy) begin
            // full freeze: every enable and flush stays low
            pc_we = 1'b0;
          end else if (lu_s) begin
            // hold PC and IF/ID, inject a bubble behind the load
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            id_ex_flush = 1'b1;
          end else if (id_op == OP_HLT) begin
            // let HLT move on, stop fetching, start the drain
            if_id_we        = 1'b1;
            id_ex_we        = 1'b1;
            ex_mem_we       = 1'b1;
            mem_wb_we       = 1'b1;
            if_id_flush     = 1'b1;
            drain_cnt_nxt_s = CW'(DRAIN_CYC);
            state_nxt_s     = S_DRAIN;
          end else if (branch_taken) begin
            // squash the wrong-path fetch; an outstanding fetch still holds the PC
            pc_we       = ~imem_busy;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            if_id_flush = 1'b1;
          end else if (imem_busy) begin
            // no instruction available: feed a NOP into IF/ID
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
          end
        end
        S_DRAIN: begin
          if (mem_busy) begin
            // frozen: counter holds, nothing moves
            drain_cnt_nxt_s = drain_cnt_r;
          end else begin
            if_id_we        = 1'b1;
            id_ex_we        = 1'b1;
            ex_mem_we       = 1'b1;
            mem_wb_we       = 1'b1;
            if_id_flush     = 1'b1;
            drain_cnt_nxt_s = drain_cnt_r - CW'(1);
            if (drain_cnt_r <= CW'(1)) begin
              drain_cnt_nxt_s = '0;
              state_nxt_s     = S_HALTED;
            end else begin
              state_nxt_s = S_DRAIN;
            end
          end
        end
        S_HALTED: begin
          state_nxt_s = S_HALTED;
        end
        default: begin
          state_nxt_s     = S_RUN;
          drain_cnt_nxt_s = '0;
        end
      endcase
    end
  end

`ifdef HZRD_PERF_EN
  logic        stall_inc_s;
  logic [15:0] stall_cnt_r;

  // A stall cycle is a RUN cycle where the PC is held by mem_busy, load-use or imem_busy.
  assign stall_inc_s = (state_r == S_RUN) &&
                       (mem_busy || lu_s || (imem_busy && (id_op != OP_HLT)));

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each issued cycle pushes the reference
// model's expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  id_op = 4'h0, id_rs = 4'h0, id_rt = 4'h0, ex_op = 4'h0, ex_rd = 4'h0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic        branch_taken = 1'b0, imem_busy = 1'b0, mem_busy = 1'b0;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, halted;
  logic [15:0] stall_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_op(ex_op), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .imem_busy(imem_busy), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // expected vector: {pc,if_id,id_ex,ex_mem,mem_wb we, if_id_flush, id_ex_flush, halted, stall_cnt}
  logic [23:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: pipeline mode, drain edges remaining, stall tally.
  int m_mode  = 0;   // 0 running, 1 draining, 2 halted
  int m_left  = 0;
  int m_stall = 0;

  // Monitor: compare every presented output cycle against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [23:0] exp_v, act_v;
      exp_v = sb.pop_front();
      act_v = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, halted, stall_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs cycle %0d: actual %h required %h (we/flush/halt bits %b vs %b)",
                 cyc, act_v, exp_v, act_v[23:16], exp_v[23:16]);
      end
    end
  end

  task automatic step(input logic r, input logic mb, input logic ib, input logic br,
                      input logic [3:0] iop, input logic [3:0] eop, input logic [3:0] erd,
                      input logic [3:0] rs, input logic [3:0] rt,
                      input logic urs, input logic urt);
    logic [7:0]  e;
    logic [15:0] es;
    logic        hz;
    rst = r; mem_busy = mb; imem_busy = ib; branch_taken = br; id_op = iop;
    ex_op = eop; ex_rd = erd; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    hz = (eop == 4'h8) && (erd != 4'h0) && ((urs && erd == rs) || (urt && erd == rt));
    e  = 8'h00;
    if (r) begin
      m_mode = 0; m_left = 0; m_stall = 0;
      es = 16'h0000;
    end else begin
      es = m_stall[15:0];
      if (m_mode == 0) begin
        if (mb)                e = 8'b0000_0000;
        else if (hz)           e = 8'b0011_1010;
        else if (iop == 4'hF) begin
          e = 8'b0111_1100; m_mode = 1; m_left = 3;
        end
        else if (br)           e = {~ib, 7'b111_1100};
        else if (ib)           e = 8'b0111_1100;
        else                   e = 8'b1111_1000;
        if (mb || hz || (ib && iop != 4'hF)) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      end else if (m_mode == 1) begin
        if (!mb) begin
          e = 8'b0111_1100;
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end else begin
        e = 8'b0000_0001;
      end
    end
`ifndef HZRD_PERF_EN
    es = 16'h0000;
`endif
    sb.push_back({e, es});
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic busy(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    do_rst();
    idle(2);
    // reset arriving mid-stall
    busy(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(2);
    // load-use, then bubble clears ex_op
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h8, 4'h3, 4'h3, 4'h5, 1'b1, 1'b0);
    idle(1);
    // load into $0 never hazards
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    // rt-side hazard
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h8, 4'h7, 4'h2, 4'h7, 1'b1, 1'b1);
    // memory wait 3 cycles
    busy(3);
    idle(1);
    // branch alone, branch with imem_busy, branch against load-use
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h8, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    // halt drain, plain
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(6);
    busy(1);
    do_rst();
    // halt drain with two frozen cycles
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1);
    busy(2);
    idle(5);
    do_rst();
    idle(1);
    // randomized episodes
    for (int ep = 0; ep < 20; ep++) begin
      do_rst();
      for (int k = 0; k < 150; k++) begin
        logic [3:0] iop;
        iop = ($urandom_range(0, 59) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        step(1'b0,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
             iop,
             ($urandom_range(0, 1) == 0) ? 4'h8 : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    idle(1);
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_scoreboard: actual %0d pending entries, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
